seg7_rx_monitor: RTL
====================

# seg7_rx_monitor

Receive-side monitor for the seven-segment display bus. It samples the seven segment lines driven by the hex counter/encoder path and synchronises them. It filters transient patterns and decodes stable patterns back to a 4-bit value. When sequence checking is compiled in, it also checks that successive values advance by +1 modulo 16, so a bench or on-board checker can confirm the display path end to end.

## Interface
- STABLE_CYCLES, default 4: consecutive cycles a synchronised pattern must hold before acceptance; legal range 1–255.
- SEG_ACTIVE_LOW, default 0: 1 means a lit segment is logic 0 on the pins.

- i_clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- i_Seg_A … i_Seg_G  input  1 each  segment lines, asynchronous to i_clk
- o_value  output  4  last accepted valid digit
- o_valid  output  1  one-cycle pulse when a new valid digit is accepted
- o_blank  output  1  level; last accepted pattern was all segments off
- o_invalid  output  1  one-cycle pulse when an undecodable pattern is accepted
- o_seq_err  output  1  one-cycle pulse when an accepted digit is not previous+1 mod 16
- o_err_count  output  8  saturating count of o_invalid and o_seq_err events

## Operation
- **Synchroniser**
  - Two-flop synchroniser on each segment line.
  - Flops reset to the unlit level.
  - Synchronised data is normalised to active-high, packed as {A,B,C,D,E,F,G}, bit 6 = A.
- **Stability filter**
  - Registers: candidate `cand` (7 bits) and counter `cnt`.
  - If the synchronised pattern differs from `cand`: load `cand`, set `cnt` = 0.
  - Otherwise `cnt` increments, saturating at STABLE_CYCLES.
  - Acceptance occurs on the edge where `cnt` goes STABLE_CYCLES−1 → STABLE_CYCLES, and only if `cand` ≠ last accepted pattern.
  - A pattern is therefore accepted at most once per appearance. A glitch that returns to the accepted pattern is never re-accepted.
- **Decode table** (hex, {A..G}):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - 00 = blank; every other pattern is invalid.
- **FSM** (states S_WAIT_FIRST, S_TRACK):
  - S_WAIT_FIRST + valid accept:
    - Update o_value, pulse o_valid, clear o_blank.
    - Go to S_TRACK. No sequence check.
  - S_TRACK + valid accept:
    - Update o_value, pulse o_valid, clear o_blank.
    - If the digit ≠ (previous o_value + 1) mod 16: pulse o_seq_err and increment o_err_count. Remain in S_TRACK.
    - F→0 is legal.
  - Blank accept, any state:
    - Set o_blank; o_value holds.
    - Go to S_WAIT_FIRST. Not an error.
  - Invalid accept, any state:
    - Pulse o_invalid, increment o_err_count; o_value and o_blank hold.
    - Go to S_WAIT_FIRST.
- **o_err_count**: saturates at 255. Only one acceptance can occur per cycle, so at most one increment per cycle.

## Timing
- Reset state:
  - o_value = 0; o_valid, o_invalid, o_seq_err = 0; o_blank = 1; o_err_count = 0.
  - FSM = S_WAIT_FIRST; last accepted pattern = 00; `cand` = 00; `cnt` = 0.
- All outputs are registered. Pulses are exactly one cycle wide.
- **Latency:** a pattern first captured by the first synchroniser flop at edge N is accepted, and its outputs updated, at edge N+2+STABLE_CYCLES. For the default of 4, that is edge N+6.
- A pattern held for fewer than STABLE_CYCLES+1 synchronised cycles is discarded silently.
- rst_n assertion mid-operation clears everything immediately, including `cnt`. The first accept after release is treated as a first value.

## Configuration
- `SEG7_SEQ_CHECK_EN` defined:
  - Sequence checking as described; o_seq_err is active.
  - S_WAIT_FIRST/S_TRACK tracking is implemented.
- Not defined:
  - No sequence comparison; o_seq_err is tied 0.
  - o_err_count counts only invalid patterns.
  - FSM state has no effect on outputs.

## Test plan
- Reset, then drive 7E stable for 10 cycles → o_valid pulse at edge N+6 (STABLE_CYCLES=4), o_value=0, o_blank=0, o_err_count=0.
- Drive digits 0…F then 0 (47→7E), each held 20 cycles → 17 o_valid pulses, F→0 gives no o_seq_err, o_err_count=0.
- Sequence 30,6D,33 (1,2,4), each held 20 cycles → o_seq_err on 4, o_err_count=1; with `SEG7_SEQ_CHECK_EN` undefined → no pulse, count 0.
- During a stable 6D, inject a 2-cycle 7F glitch → no o_valid, no o_invalid, o_value stays 2.
- Drive 01 (invalid) for 20 cycles, then 5B → o_invalid pulse, count+1; 5B accepted as first value with no o_seq_err. Drive 00 → o_blank=1, no error.
- Assert rst_n mid-stream with count=3 → all outputs return to reset values at once, o_blank=1. Repeat the invalid-pattern test with SEG_ACTIVE_LOW=1 and inverted pins → identical results.

Source files
------------

// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: receive-side monitor for the seven-segment display bus.
// Synchronises the segment lines, filters transient patterns, decodes stable
// patterns back to a hex digit and counts error events.
// Optional feature macro: SEG7_SEQ_CHECK_EN enables the +1 mod 16 sequence check.
module seg7_rx_monitor #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic       i_Seg_A,
  input  logic       i_Seg_B,
  input  logic       i_Seg_C,
  input  logic       i_Seg_D,
  input  logic       i_Seg_E,
  input  logic       i_Seg_F,
  input  logic       i_Seg_G,
  output logic [3:0] o_value,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_invalid,
  output logic       o_seq_err,
  output logic [7:0] o_err_count
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam logic [SEG_W-1:0] UNLIT  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0] seg_raw_c;
  logic [SEG_W-1:0] sync1;
  logic [SEG_W-1:0] sync2;
  logic [SEG_W-1:0] seg_norm_c;
  logic [SEG_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [SEG_W-1:0] last_pat;
  logic             accept_c;
  logic             dec_ok_c;
  logic [3:0]       dec_digit_c;
  logic             is_blank_c;

  assign seg_raw_c  = {i_Seg_A, i_Seg_B, i_Seg_C, i_Seg_D, i_Seg_E, i_Seg_F, i_Seg_G};
  // XOR with the unlit level turns active-low pins into active-high data
  assign seg_norm_c = sync2 ^ UNLIT;

  // Two-flop synchroniser, reset to the unlit pin level
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= UNLIT;
      sync2 <= UNLIT;
    end else begin
      sync1 <= seg_raw_c;
      sync2 <= sync1;
    end
  end

  // Stability filter: candidate pattern and saturating hold counter
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (seg_norm_c != cand) begin
      cand <= seg_norm_c;
      cnt  <= '0;
    end else if (cnt != STABLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Accept once per appearance, on the counter's final step
  assign accept_c = (seg_norm_c == cand) && (cnt == STABLE - CNT_W'(1)) && (cand != last_pat);
  assign is_blank_c = (cand == '0);

  // Pattern-to-digit decode of the candidate
  always_comb begin
    dec_ok_c    = 1'b1;
    dec_digit_c = 4'h0;
    case (cand)
      7'h7E: dec_digit_c = 4'h0;
      7'h30: dec_digit_c = 4'h1;
      7'h6D: dec_digit_c = 4'h2;
      7'h79: dec_digit_c = 4'h3;
      7'h33: dec_digit_c = 4'h4;
      7'h5B: dec_digit_c = 4'h5;
      7'h5F: dec_digit_c = 4'h6;
      7'h70: dec_digit_c = 4'h7;
      7'h7F: dec_digit_c = 4'h8;
      7'h7B: dec_digit_c = 4'h9;
      7'h77: dec_digit_c = 4'hA;
      7'h1F: dec_digit_c = 4'hB;
      7'h4E: dec_digit_c = 4'hC;
      7'h3D: dec_digit_c = 4'hD;
      7'h4F: dec_digit_c = 4'hE;
      7'h47: dec_digit_c = 4'hF;
      default: dec_ok_c = 1'b0;
    endcase
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef SEG7_SEQ_CHECK_EN
  typedef enum logic {S_WAIT_FIRST = 1'b0, S_TRACK = 1'b1} state_t;
  state_t state;

  // Acceptance handling with first-value / sequence tracking FSM
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT_FIRST;
      last_pat    <= '0;
      o_value     <= 4'h0;
      o_valid     <= 1'b0;
      o_blank     <= 1'b1;
      o_invalid   <= 1'b0;
      o_seq_err   <= 1'b0;
      o_err_count <= 8'h00;
    end else begin
      o_valid   <= 1'b0;
      o_invalid <= 1'b0;
      o_seq_err <= 1'b0;
      if (accept_c) begin
        last_pat <= cand;
        if (dec_ok_c) begin
          o_value <= dec_digit_c;
          o_valid <= 1'b1;
          o_blank <= 1'b0;
          if ((state == S_TRACK) && (dec_digit_c != o_value + 4'd1)) begin
            o_seq_err   <= 1'b1;
            o_err_count <= sat_inc(o_err_count);
          end
          state <= S_TRACK;
        end else if (is_blank_c) begin
          o_blank <= 1'b1;
          state   <= S_WAIT_FIRST;
        end else begin
          o_invalid   <= 1'b1;
          o_err_count <= sat_inc(o_err_count);
          state       <= S_WAIT_FIRST;
        end
      end
    end
  end
`else
  assign o_seq_err = 1'b0;

  // Acceptance handling without sequence tracking
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pat    <= '0;
      o_value     <= 4'h0;
      o_valid     <= 1'b0;
      o_blank     <= 1'b1;
      o_invalid   <= 1'b0;
      o_err_count <= 8'h00;
    end else begin
      o_valid   <= 1'b0;
      o_invalid <= 1'b0;
      if (accept_c) begin
        last_pat <= cand;
        if (dec_ok_c) begin
          o_value <= dec_digit_c;
          o_valid <= 1'b1;
          o_blank <= 1'b0;
        end else if (is_blank_c) begin
          o_blank <= 1'b1;
        end else begin
          o_invalid   <= 1'b1;
          o_err_count <= sat_inc(o_err_count);
        end
      end
    end
  end
`endif

endmodule
